gpio_sequencer: RTL

Programmable pattern player that owns the write side of a `gpio_device` control port. It steps a small pattern RAM onto one 16-bit output word of the GPIO device at a fixed cycle period, and arbitrates that device port between itself and the CPU. The CPU always wins, and sequencer writes stall until the port is free. It sits between the CPU device bus and `gpio_device` and exposes its own control-register window on the device bus.

---
 rtl/gpio_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gpio_sequencer.sv
// gpio_sequencer: plays a pattern RAM onto a gpio_device output word while arbitrating the device port with the CPU.
// Define GPIO_SEQ_LOOP_EN to implement CTRL.LOOP (continuous replay); otherwise every run is one-shot.
module gpio_sequencer #(
  parameter logic [15:0] DEVICE_ID = 16'h0,
  parameter logic [7:0] DEVICE_TYPE = 8'h9,
  parameter int DEPTH = 16
) (
  input  logic cpu_clock,
  input  logic reset_n,
  input  logic is_control,
  input  logic write_enable,
  input  logic [7:0] short_address,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic cpu_gpio_sel,
  input  logic cpu_gpio_write,
  input  logic [7:0] cpu_gpio_address,
  output logic dev_is_control,
  output logic dev_write_enable,
  output logic [7:0] dev_short_address,
  output logic [15:0] dev_data,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
`ifdef GPIO_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic run, loop_q, done;
  logic [15:0] period, length, cnt, per_eff, rd;
  logic [16:0] len_eff;
  logic [AW-1:0] index, ptr;
  logic [1:0] target;
  logic [15:0] pattern [DEPTH];
  logic wr, ctrl_wr, start, stop, step, last, issue, unused;
  assign unused = ^short_address[7:4];
  assign wr = is_control & write_enable;
  assign ctrl_wr = wr & (short_address[3:0] == 4'd2);
  assign start = ctrl_wr & cpu_data_in[0] & ~run;
  assign stop = ctrl_wr & ~cpu_data_in[0] & run;
  assign per_eff = (period == 16'd0) ? 16'd1 : period;
  assign len_eff = (length == 16'd0) ? 17'd1 :
                   ({1'b0, length} > 17'(DEPTH)) ? 17'(DEPTH) : {1'b0, length};
  assign issue = (state == ISSUE);
  // PERIOD of 1 decides straight out of ISSUE, so writes land back-to-back
  assign step = (issue & ~cpu_gpio_sel & (per_eff == 16'd1)) |
                ((state == WAIT) & (({1'b0, cnt} + 17'd1) >= {1'b0, per_eff}));
  assign last = ({{(17-AW){1'b0}}, index} + 17'd1) >= len_eff;
  assign busy = (state != IDLE);
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      run <= 1'b0;
      loop_q <= 1'b0;
      done <= 1'b0;
      period <= 16'h0;
      length <= 16'h0;
      cnt <= 16'h0;
      index <= '0;
      ptr <= '0;
      target <= 2'b0;
    end else begin
      if (wr)
        case (short_address[3:0])
          4'd2: begin
            loop_q <= LOOP_EN & cpu_data_in[1];
            if (cpu_data_in[3]) done <= 1'b0;
          end
          4'd3: period <= cpu_data_in;
          4'd4: length <= cpu_data_in;
          4'd6: target <= cpu_data_in[1:0];
          4'd7: ptr <= cpu_data_in[AW-1:0];
          4'd8: ptr <= ptr + 1'b1;
          default: ;
        endcase
      if (start) begin
        run <= 1'b1;
        index <= '0;
        state <= ISSUE;
      end else if (stop) begin
        run <= 1'b0;
        state <= IDLE;
      end else if (step) begin
        if (!last) begin
          index <= index + 1'b1;
          state <= ISSUE;
        end else if (loop_q) begin
          index <= '0;
          state <= ISSUE;
        end else begin
          run <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      end else if (issue && !cpu_gpio_sel) begin
        cnt <= 16'd1;
        state <= WAIT;
      end else if (state == WAIT)
        cnt <= cnt + 16'd1;
    end
  end
  always_ff @(posedge cpu_clock)
    if (wr && short_address[3:0] == 4'd8) pattern[ptr] <= cpu_data_in;
  always_comb begin
    rd = 16'h0;
    case (short_address[3:0])
      4'd0: rd = DEVICE_ID;
      4'd1: rd = {8'(AW), DEVICE_TYPE};
      4'd2: rd = {12'h0, done, busy, loop_q, run};
      4'd3: rd = period;
      4'd4: rd = length;
      4'd5: rd = 16'(index);
      4'd6: rd = {14'h0, target};
      4'd7: rd = 16'(ptr);
      default: rd = 16'h0;
    endcase
    cpu_data_out = is_control ? rd : 16'h0;
  end
  assign dev_is_control = cpu_gpio_sel | issue;
  assign dev_write_enable = cpu_gpio_sel ? cpu_gpio_write : issue;
  assign dev_short_address = cpu_gpio_sel ? cpu_gpio_address : issue ? 8'h08 + {6'h0, target} : 8'h0;
  assign dev_data = cpu_gpio_sel ? cpu_data_in : issue ? pattern[index] : 16'h0;
endmodule
